ud_counter_ctrl: RTL

//  Run/pause/stop sequencer for the up/down counter datapath. Owns the clock-enable

---
 rtl/ud_ctrl_pkg.sv | 40 ++++
 rtl/ud_tick_gen.sv | 81 ++++++++
 rtl/ud_counter_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ud_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ud_ctrl_pkg
//   Shared definitions for the up/down counter controller.
//   - ctrl_state_e : sequencer state encodings (IDLE / RUN / PAUSE).
//   - MIN_DIV      : smallest divisor the prescaler will ever use.
//   - rate_div()   : maps a 2-bit rate select onto a clock divisor.
//     Returns the number of clock cycles per count step.
// ---------------------------------------------------------------------------
package ud_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } ctrl_state_e;

  // A divisor of 1 would leave no room for the prescaler to return to
  // zero between ticks.
  localparam int unsigned MIN_DIV = 2;

  // sel 0: clk_hz, 1: clk_hz/2, 2: clk_hz/4, 3: clk_hz/10.
  // All divisors are integer-truncated and clamped to MIN_DIV.
  // clk_hz is always a parameter, so this folds into a 4-way
  // constant mux driven by sel.
  function automatic int unsigned rate_div(input int unsigned clk_hz,
                                           input logic [1:0]  sel);
    int unsigned d;
    case (sel)
      2'd0:    d = clk_hz;
      2'd1:    d = clk_hz / 2;
      2'd2:    d = clk_hz / 4;
      default: d = clk_hz / 10;
    endcase
    if (d < MIN_DIV) begin
      d = MIN_DIV;
    end
    return d;
  endfunction

endpackage

// File: rtl/ud_tick_gen.sv
// ---------------------------------------------------------------------------
// ud_tick_gen
//   Clock-enable prescaler.
//   It divides the clock by a runtime-selectable divisor and produces a
//   registered one-cycle tick. The divisor is reloaded from rate_sel only
//   while the prescaler sits at zero. A rate change made mid-period
//   therefore takes effect from the next period.
//
//   Ports
//     clk       in  1      clock, rising edge
//     rst       in  1      synchronous, active-high
//     en        in  1      count enable (controller is in RUN)
//     clr       in  1      force prescaler to 0 (IDLE, or PAUSE->IDLE)
//     rate_sel  in  2      divisor select, see ud_ctrl_pkg::rate_div
//     step      out 1      combinational: the coming edge ends a period
//     tick      out 1      registered one-cycle pulse, concurrent with step's edge
// ---------------------------------------------------------------------------
module ud_tick_gen
  import ud_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned PRESC_W = $clog2(CLK_HZ)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] rate_sel,
  output logic       step,
  output logic       tick
);

  // Terminal value (divisor - 1) is stored instead of the divisor itself.
  // It then always fits in PRESC_W bits, even when the divisor equals CLK_HZ.
  localparam logic [PRESC_W-1:0] TERM_RESET = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] term_q,  term_d;
  logic               tick_q,  tick_d;

  assign step = en && !clr && (presc_q == term_q);

  always_comb begin
    presc_d = presc_q;
    term_d  = term_q;
    tick_d  = 1'b0;

    // The divisor is latched only at prescaler zero.
    // While at zero, the compare below can never match, since term >= 1.
    // So a reload here cannot shorten the current period.
    if (presc_q == '0) begin
      term_d = PRESC_W'(rate_div(CLK_HZ, rate_sel) - 32'd1);
    end

    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q == term_q) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      term_q  <= TERM_RESET;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      term_q  <= term_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ud_counter_ctrl.sv
// ---------------------------------------------------------------------------
// ud_counter_ctrl
//   Run/pause/stop sequencer for the up/down counter datapath.
//   It edge-detects the start/stop buttons, runs the IDLE/RUN/PAUSE FSM,
//   and owns the bounded modulo count register.
//   The prescaler lives in ud_tick_gen. Single clock domain; it produces
//   only enables, never derived clocks.
//
//   Parameters
//     CLK_HZ     clock frequency; base divisor for rate 0
//     COUNT_W    width of count
//     MAX_COUNT  highest count value; counter is modulo MAX_COUNT+1
//
//   Ports
//     clock_in   in  1        sole clock, rising edge
//     reset      in  1        synchronous, active-high
//     btn_start  in  1        synchronised level; rising edge starts/resumes
//     btn_stop   in  1        synchronised level; rising edge pauses/stops
//     dir_up     in  1        1 = up, 0 = down; sampled on each tick
//     rate_sel   in  2        0:CLK_HZ 1:/2 2:/4 3:/10 cycles per step
//     load       in  1        level; preset count (IDLE/PAUSE only)
//     load_val   in  COUNT_W  preset value, clamped to MAX_COUNT
//     count      out COUNT_W  current count
//     tick       out 1        one-cycle pulse, same cycle count shows new value
//     wrap       out 1        one-cycle pulse with tick when count wrapped
//     state      out 2        0 IDLE, 1 RUN, 2 PAUSE
// ---------------------------------------------------------------------------
module ud_counter_ctrl
  import ud_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned MAX_COUNT = 99
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               dir_up,
  input  logic [1:0]         rate_sel,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               wrap,
  output logic [1:0]         state
);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  // Edge-detect history and registered pulses.
  // A pulse acts one cycle after its input rises.
  logic btn_start_q, btn_stop_q;
  logic start_p_q,   start_p_d;
  logic stop_p_q,    stop_p_d;

  ctrl_state_e        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wrap_q,  wrap_d;

  logic clear_now;
  logic presc_en;
  logic presc_clr;
  logic step;
  logic load_ok;

  assign start_p_d = btn_start & ~btn_start_q;
  assign stop_p_d  = btn_stop  & ~btn_stop_q;

  // ------------------------------------------------------------------
  // Sequencer next state. When both pulses arrive together, stop wins.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p_q && !stop_p_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_p_q) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_p_q)       state_d = ST_IDLE;
        else if (start_p_q) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stop from PAUSE clears both the count and the prescaler.
  assign clear_now = (state_q == ST_PAUSE) && stop_p_q;

  // The prescaler runs only in RUN and holds its value in PAUSE.
  // It is kept at zero in IDLE, and in the unused encoding.
  assign presc_en  = (state_q == ST_RUN);
  assign presc_clr = clear_now ||
                     ((state_q != ST_RUN) && (state_q != ST_PAUSE));

  assign load_ok   = load && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));

  ud_tick_gen #(
    .CLK_HZ   (CLK_HZ)
  ) u_tick_gen (
    .clk      (clock_in),
    .rst      (reset),
    .en       (presc_en),
    .clr      (presc_clr),
    .rate_sel (rate_sel),
    .step     (step),
    .tick     (tick)
  );

  // ------------------------------------------------------------------
  // Count register.
  // step is only ever asserted in RUN, and load is only honoured in
  // IDLE/PAUSE, so the two are mutually exclusive. The clear on
  // PAUSE->IDLE takes priority over a concurrent load.
  // ------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear_now) begin
      count_d = '0;
    end else if (step) begin
      if (dir_up) begin
        if (count_q == MAX_C) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
    end else if (load_ok) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end
  end

  // ------------------------------------------------------------------
  // State, count and output registers.
  // During reset the button history follows the inputs. A button held
  // through reset release therefore does not look like a fresh press.
  // With the buttons low, the history resets to zero.
  // ------------------------------------------------------------------
  always_ff @(posedge clock_in) begin
    if (reset) begin
      btn_start_q <= btn_start;
      btn_stop_q  <= btn_stop;
      start_p_q   <= 1'b0;
      stop_p_q    <= 1'b0;
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      btn_start_q <= btn_start;
      btn_stop_q  <= btn_stop;
      start_p_q   <= start_p_d;
      stop_p_q    <= stop_p_d;
      state_q     <= state_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule
